// File: rtl/kyber_pkg.sv
// Shared Kyber constants, decoder state type and the legal-width check
// used by the byte/coefficient packing datapath.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dec_state_t;

    function automatic logic legal_d(input logic [3:0] d);
        case (d)
            4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_sub_q.sv
// Single conditional subtraction of Q: maps [0, 2^W) onto [0, Q) for inputs
// below 2Q. Shared with the compress/decompress datapath.
module cond_sub_q
    import kyber_pkg::*;
#(
    parameter int W = 12,
    parameter int Q = KYBER_Q
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = (x >= W'(Q)) ? x - W'(Q) : x;

endmodule

// File: rtl/byte_decode_stream.sv
// Streaming Kyber ByteDecode_d: packs an LSB-first byte stream into d-bit
// coefficients, one polynomial per start, with mod-q reduction for d=12.
module byte_decode_stream
    import kyber_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int MAX_D   = 12,
    parameter int N_COEFF = KYBER_N,
    parameter int Q       = KYBER_Q
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       d_sel,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [MAX_D-1:0] out_coeff,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int ACC_W = MAX_D + IN_W;
    localparam int CNT_W = $clog2(ACC_W);
    localparam int CC_W  = $clog2(N_COEFF);
    localparam int BPD   = N_COEFF / IN_W;
    localparam int BL_W  = $clog2(BPD * MAX_D + 1);

    dec_state_t        state_reg;
    logic [3:0]        d_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]  acc_cnt_reg;
    logic [CC_W-1:0]   coeff_cnt_reg;
    logic [BL_W-1:0]   bytes_left_reg;
    logic              done_reg;
    logic              err_reg;

    logic              run;
    logic [CNT_W-1:0]  d_ext;
    logic              in_fire;
    logic              out_fire;
    logic [MAX_D-1:0]  raw;
    logic [MAX_D-1:0]  reduced;
    logic [MAX_D-1:0]  coeff_sel;

    assign run   = (state_reg == RUN);
    assign d_ext = CNT_W'(d_reg);

    // acc_cnt < d and acc_cnt >= d are complementary, so at most one side
    // of the block can handshake in any cycle.
    assign in_ready  = run && (acc_cnt_reg < d_ext) && (bytes_left_reg != '0);
    assign out_valid = run && (acc_cnt_reg >= d_ext);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Keep only the low d bits of the accumulator as the raw coefficient.
    generate
        for (genvar gi = 0; gi < MAX_D; gi++) begin : g_mask
            assign raw[gi] = acc_reg[gi] & (CNT_W'(gi) < d_ext);
        end
    endgenerate

    cond_sub_q #(
        .W (MAX_D),
        .Q (Q)
    ) u_cond_sub_q (
        .x (raw),
        .y (reduced)
    );

    assign coeff_sel = (d_reg == 4'(MAX_D)) ? reduced : raw;
    assign out_coeff = out_valid ? coeff_sel : '0;
    assign out_last  = out_valid && (coeff_cnt_reg == CC_W'(N_COEFF - 1));
    assign busy      = run;
    assign done      = done_reg;
    assign err       = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            d_reg          <= '0;
            acc_reg        <= '0;
            acc_cnt_reg    <= '0;
            coeff_cnt_reg  <= '0;
            bytes_left_reg <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (legal_d(d_sel)) begin
                            state_reg      <= RUN;
                            d_reg          <= d_sel;
                            acc_reg        <= '0;
                            acc_cnt_reg    <= '0;
                            coeff_cnt_reg  <= '0;
                            bytes_left_reg <= BL_W'(d_sel) * BL_W'(BPD);
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        acc_reg        <= acc_reg | (ACC_W'(in_data) << acc_cnt_reg);
                        acc_cnt_reg    <= acc_cnt_reg + CNT_W'(IN_W);
                        bytes_left_reg <= bytes_left_reg - 1'b1;
                    end else if (out_fire) begin
                        acc_reg       <= acc_reg >> d_reg;
                        acc_cnt_reg   <= acc_cnt_reg - d_ext;
                        coeff_cnt_reg <= coeff_cnt_reg + 1'b1;
                        if (out_last) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_decode_stream.sv
// Randomized bench for byte_decode_stream against a bit-stream reference model.
module tb_byte_decode_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  d_sel;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_coeff;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    byte_decode_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .d_sel     (d_sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_coeff (out_coeff),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] bytes_arr [0:383];
    int         lit_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: coefficient k is stream bits [k*d, k*d+d-1], LSB first.
    function automatic int model_coeff(input int d, input int k);
        int v = 0;
        for (int i = 0; i < d; i++) begin
            int b = k * d + i;
            if (bytes_arr[b / 8][b % 8]) v |= (1 << i);
        end
        if (d == 12 && v >= 3329) v -= 3329;
        return v;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 384; i++) bytes_arr[i] = 8'($urandom);
        lit_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},  int'(in_ready),  0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_coeff"}, int'(out_coeff), 0);
        chk({tag, "_out_last"},  int'(out_last),  0);
        chk({tag, "_busy"},      int'(busy),      0);
        chk({tag, "_done"},      int'(done),      0);
        chk({tag, "_err"},       int'(err),       0);
    endtask

    // Decode one polynomial starting at a negedge; returns at the negedge of
    // the done cycle, or one cycle after a reset if abort_at is reached.
    task automatic run_poly(input int d, input bit stall, input int abort_at,
                            input int restart_at);
        int  bi = 0;
        int  ci = 0;
        int  busy_cyc = 0;
        bit  fin = 1'b0;
        bit  prev_hold = 1'b0;
        int  prev_coeff = 0;
        int  prev_last = 0;
        int  k;
        start = 1'b1;
        d_sel = 4'(d);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("in_ready_after_start", int'(in_ready), 1);
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (busy) busy_cyc++;
            if (in_ready && out_valid) chk("ready_valid_exclusive", 1, 0);
            if (prev_hold) begin
                chk("stall_valid_held", int'(out_valid), 1);
                chk("stall_coeff_held", int'(out_coeff), prev_coeff);
                chk("stall_last_held", int'(out_last), prev_last);
            end
            if (abort_at >= 0 && ci == abort_at) begin
                rst = 1'b1;
                in_valid = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_all_zero("abort");
                return;
            end
            in_valid  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = bytes_arr[bi < 384 ? bi : 383];
            if (restart_at >= 0 && ci == restart_at && !out_valid) begin
                start = 1'b1;
                d_sel = 4'd1;
                restart_at = -1;
            end
            if (in_valid && in_ready) bi++;
            if (out_valid && out_ready) begin
                k = ci;
                chk($sformatf("coeff_d%0d_k%0d", d, k), int'(out_coeff), model_coeff(d, k));
                if (k < lit_q.size())
                    chk($sformatf("literal_d%0d_k%0d", d, k), int'(out_coeff), lit_q[k]);
                chk($sformatf("last_k%0d", k), int'(out_last), (k == 255) ? 1 : 0);
                ci++;
                if (ci == 256) fin = 1'b1;
            end
            prev_hold  = out_valid && !out_ready;
            prev_coeff = int'(out_coeff);
            prev_last  = int'(out_last);
            @(negedge clk);
            start = 1'b0;
            if (fin) begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
                chk("done_pulse", int'(done), 1);
                chk("busy_low_at_done", int'(busy), 0);
                chk("bytes_consumed", bi, 32 * d);
                chk("coeff_count", ci, 256);
                if (!stall) chk("cycle_count", busy_cyc, 32 * d + 256);
                $display("poly d=%0d stall=%0d: %0d coeffs, %0d busy cycles", d, stall, ci, busy_cyc);
                return;
            end
        end
        chk("poly_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; d_sel = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // d=12 basic: 0x19 D7 4A -> 0x719, 0x4AD
        fill_random();
        bytes_arr[0] = 8'h19; bytes_arr[1] = 8'hD7; bytes_arr[2] = 8'h4A;
        lit_q = '{1817, 1197};
        run_poly(12, 1'b0, -1, -1);

        // d=1 bit order, back-to-back start in the done cycle
        fill_random();
        bytes_arr[0] = 8'h19;
        lit_q = '{1, 0, 0, 1, 1, 0, 0, 0};
        run_poly(1, 1'b0, -1, -1);

        // d=12 mod-q reduction with stalls
        fill_random();
        bytes_arr[0] = 8'hFF; bytes_arr[1] = 8'hFF; bytes_arr[2] = 8'hFF;
        lit_q = '{766, 766};
        run_poly(12, 1'b1, -1, -1);

        // d=4 with stalls, then unstalled
        fill_random();
        bytes_arr[0] = 8'h19;
        lit_q = '{9, 1};
        run_poly(4, 1'b1, -1, -1);
        fill_random();
        run_poly(4, 1'b0, -1, -1);

        // illegal widths
        foreach (lit_q[i]) lit_q[i] = lit_q[i];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1;
            d_sel = (i == 0) ? 4'd7 : (i == 1) ? 4'd0 : 4'd13;
            @(negedge clk);
            start = 1'b0;
            chk("err_pulse", int'(err), 1);
            chk("err_no_busy", int'(busy), 0);
            @(negedge clk);
            chk("err_one_cycle", int'(err), 0);
        end

        // remaining widths, one with a start issued mid-run
        fill_random();
        run_poly(5, 1'b1, -1, -1);
        fill_random();
        run_poly(10, 1'b0, -1, 40);

        // reset after 100 coefficients, then a fresh d=10 polynomial
        fill_random();
        run_poly(11, 1'b1, 100, -1);
        fill_random();
        run_poly(10, 1'b1, -1, -1);

        @(negedge clk);
        chk("done_cleared", int'(done), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
